// File: rtl/key_stroke_driver_pkg.sv
// Shared doorlock keypad definitions: key width, driver FSM states and default timing.
package key_stroke_driver_pkg;

  localparam int KEY_W           = 8;
  localparam int HOLD_CYCLES_DEF = 4;
  localparam int GAP_CYCLES_DEF  = 2;
  localparam int DEPTH_DEF       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } key_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_stroke_driver_fifo.sv
// Single-clock key FIFO; storage is not reset, only pointers and occupancy are.
module key_fifo
  import key_stroke_driver_pkg::*;
#(
  parameter int WIDTH = KEY_W,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_stroke_driver.sv
// Replays queued key codes as held levels separated by zero gaps, so a downstream
// rising-edge detector sees exactly one edge per key.
module key_stroke_driver
  import key_stroke_driver_pkg::*;
#(
  parameter int WIDTH       = KEY_W,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int GAP_CYCLES  = GAP_CYCLES_DEF,
  parameter int DEPTH       = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] key_code,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [WIDTH-1:0] key_signal,
  output logic             busy,
  output logic             key_done,
  output logic             zero_drop
);

  localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES));
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  key_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             accept;
  logic             push;
  logic             pop;

  // Ready comes only from registered occupancy; a same-cycle pop never frees a slot.
  assign key_ready = !fifo_full;
  assign accept    = key_valid && key_ready;
  assign push      = accept && (key_code != '0);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE) pop = 1'b1;
      else if (state == GAP && cnt == '0) pop = 1'b1;
    end
  end

  key_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (key_code),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      key_signal <= '0;
      key_done   <= 1'b0;
    end else begin
      key_done <= 1'b0;
      case (state)
        IDLE: begin
          key_signal <= '0;
          if (pop) begin
            key_signal <= fifo_head;
            cnt        <= HOLD_LOAD;
            state      <= PRESS;
          end
        end
        PRESS: begin
          if (cnt == '0) begin
            key_signal <= '0;
            cnt        <= GAP_LOAD;
            state      <= GAP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) begin
            key_done <= 1'b1;
            // Chain straight into the next key so back-to-back keys keep a fixed period.
            if (pop) begin
              key_signal <= fifo_head;
              cnt        <= HOLD_LOAD;
              state      <= PRESS;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          key_signal <= '0;
          cnt        <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) zero_drop <= 1'b0;
    else        zero_drop <= accept && (key_code == '0);
  end

endmodule

// File: tb/tb_key_stroke_driver.sv
// Directed bench for key_stroke_driver with a two-stage edge-detector model on key_signal.
module tb_key_stroke_driver;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [7:0] key_signal;
  logic       busy;
  logic       key_done;
  logic       zero_drop;

  int n_checks = 0;
  int n_pass   = 0;

  key_stroke_driver #(
    .WIDTH       (8),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (2),
    .DEPTH       (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_signal (key_signal),
    .busy       (busy),
    .key_done   (key_done),
    .zero_drop  (zero_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream edge detector: fires when stage 1 is nonzero and stage 2 is zero.
  logic [7:0] det_s1;
  logic [7:0] det_s2;
  int         edge_cnt = 0;
  logic [7:0] edge_last;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_s1 <= '0;
      det_s2 <= '0;
    end else begin
      if (det_s1 != 0 && det_s2 == 0) begin
        edge_cnt  <= edge_cnt + 1;
        edge_last <= det_s1;
      end
      det_s1 <= key_signal;
      det_s2 <= det_s1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [7:0] burst_codes [6];
  logic [7:0] twin_seq [14];
  logic [7:0] exp_sig;
  int         e0;

  initial begin
    burst_codes = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};
    twin_seq    = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00,
                    8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n     = 1'b0;
    key_code  = '0;
    key_valid = 1'b0;
    #1;
    chk("rst_key_signal", key_signal, 8'h00);
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_key_done", key_done, 1'b0);
    chk("rst_zero_drop", zero_drop, 1'b0);
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single key 04: held 4 cycles from one cycle after acceptance, then 2 zeros.
    e0 = edge_cnt;
    key_code  = 8'h04;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("single_accept_sig", key_signal, 8'h00);
    chk("single_accept_busy", busy, 1'b1);
    for (int i = 1; i <= 7; i++) begin
      step();
      chk($sformatf("single_sig[%0d]", i), key_signal, (i <= 4) ? 8'h04 : 8'h00);
      chk($sformatf("single_done[%0d]", i), key_done, (i == 7) ? 1'b1 : 1'b0);
    end
    step();
    chk("single_done_clear", key_done, 1'b0);
    chk("single_idle_busy", busy, 1'b0);
    step();
    chk("single_edges", edge_cnt - e0, 1);
    chk("single_edge_val", edge_last, 8'h04);

    // Zero code: handshake completes, dropped, nothing driven.
    key_code  = 8'h00;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    chk("zero_drop_pulse", zero_drop, 1'b1);
    chk("zero_busy", busy, 1'b0);
    chk("zero_sig", key_signal, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("zero_drop_clear[%0d]", i), zero_drop, 1'b0);
      chk($sformatf("zero_sig_idle[%0d]", i), key_signal, 8'h00);
      chk($sformatf("zero_busy_idle[%0d]", i), busy, 1'b0);
    end

    // Burst of five, then 20 held on valid while full; it lands only after a slot frees.
    e0 = edge_cnt;
    for (int t = 0; t <= 38; t++) begin
      if (t <= 8) begin
        key_valid = 1'b1;
        key_code  = (t < 5) ? burst_codes[t] : 8'h20;
      end else begin
        key_valid = 1'b0;
      end
      step();
      if (t >= 1 && (t - 1) / 6 < 6 && (t - 1) % 6 < 4) exp_sig = burst_codes[(t - 1) / 6];
      else exp_sig = 8'h00;
      chk($sformatf("burst_sig[%0d]", t), key_signal, exp_sig);
      chk($sformatf("burst_done[%0d]", t), key_done, (t >= 7 && (t - 1) % 6 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("burst_ready[%0d]", t), key_ready, (t < 4 || t == 7 || t >= 13) ? 1'b1 : 1'b0);
    end
    key_valid = 1'b0;
    chk("burst_idle_busy", busy, 1'b0);
    chk("burst_edges", edge_cnt - e0, 6);
    chk("burst_last_edge", edge_last, 8'h20);

    // Two identical consecutive keys each get their own gap and edge.
    e0 = edge_cnt;
    key_code  = 8'h20;
    key_valid = 1'b1;
    step();
    step();
    key_valid = 1'b0;
    chk("twin_sig[1]", key_signal, twin_seq[0]);
    for (int t = 2; t <= 14; t++) begin
      step();
      chk($sformatf("twin_sig[%0d]", t), key_signal, twin_seq[t - 1]);
      chk($sformatf("twin_done[%0d]", t), key_done, (t == 7 || t == 13) ? 1'b1 : 1'b0);
    end
    chk("twin_edges", edge_cnt - e0, 2);

    // Reset mid-PRESS of 40 with two keys queued.
    key_valid = 1'b1;
    key_code  = 8'h40;
    step();
    key_code  = 8'h01;
    step();
    key_code  = 8'h02;
    step();
    key_valid = 1'b0;
    chk("abort_press_sig", key_signal, 8'h40);
    chk("abort_press_busy", busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_async_sig", key_signal, 8'h00);
    chk("abort_async_ready", key_ready, 1'b1);
    chk("abort_async_busy", busy, 1'b0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk($sformatf("abort_after_sig[%0d]", i), key_signal, 8'h00);
      chk($sformatf("abort_after_done[%0d]", i), key_done, 1'b0);
      chk($sformatf("abort_after_busy[%0d]", i), busy, 1'b0);
    end
    chk("abort_after_ready", key_ready, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
